// File: rtl/debruijn_pkg.sv
// Shared constants and helpers for the de Bruijn / maximal-length LFSR generator.
// Tap masks are for a right-shifting Fibonacci register; bit 0 is always a tap.
package debruijn_pkg;

    localparam int WIDTH_MIN = 3;
    localparam int WIDTH_MAX = 8;

    function automatic logic [WIDTH_MAX-1:0] taps(input int n);
        case (n)
            3:       return 8'b0000_0011;
            4:       return 8'b0000_0011;
            5:       return 8'b0000_0101;
            6:       return 8'b0000_0011;
            7:       return 8'b0000_0011;
            8:       return 8'b0001_1101;
            default: return 8'b0000_0011;
        endcase
    endfunction

    // Mode 1 adds the all-zero state to the 2^N-1 LFSR cycle.
    function automatic int unsigned period(input int n, input logic mode);
        return mode ? (32'd1 << n) : ((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: tick is high for one enabled cycle out of every DIV.
// clr restarts the count and suppresses a coincident tick.
module clk_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = en && !clr && (div_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/debruijn_gen.sv
// N-bit sequence generator: maximal LFSR (mode 0) or full de Bruijn cycle (mode 1),
// with seed load, run enable, clock-enable divider and period position tracking.
module debruijn_gen
    import debruijn_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter int               DIV        = 4,
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] state,
    output logic             step,
    output logic             wrap,
    output logic [WIDTH-1:0] count
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || DIV < 1) begin : g_param_check
        $fatal(1, "debruijn_gen: WIDTH must be 3..8 and DIV >= 1");
    end

    localparam logic [WIDTH_MAX-1:0] TAPS_FULL = taps(WIDTH);
    localparam logic [WIDTH-1:0]     TAP_MASK  = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH:0]       PER0      = (WIDTH+1)'(period(WIDTH, 1'b0));
    localparam logic [WIDTH:0]       PER1      = (WIDTH+1)'(period(WIDTH, 1'b1));

    logic             mode_q;
    logic             mode_chg;
    logic             tick;
    logic             fb;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH:0]   count_inc;
    logic [WIDTH:0]   per_sel;

    assign mode_chg = (mode != mode_q);

    clk_en_div #(
        .DIV (DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load | mode_chg),
        .tick (tick)
    );

    always_comb begin
        // The de Bruijn term splices 0..0 in between 0..01 and 10..0.
        fb = (^(state & TAP_MASK)) ^ (mode_q & (state[WIDTH-1:1] == '0));
        if (!mode_q && state == '0) begin
            next_state = WIDTH'(1);
        end else begin
            next_state = {fb, state[WIDTH-1:1]};
        end
        load_val  = (!mode && seed == '0) ? WIDTH'(1) : seed;
        count_inc = {1'b0, count} + 1'b1;
        per_sel   = mode_q ? PER1 : PER0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RESET_SEED;
            count  <= '0;
            step   <= 1'b0;
            wrap   <= 1'b0;
            mode_q <= mode;
        end else begin
            mode_q <= mode;
            step   <= 1'b0;
            wrap   <= 1'b0;
            if (load) begin
                state <= load_val;
                count <= '0;
            end else if (mode_chg) begin
                count <= '0;
            end else if (tick) begin
                state <= next_state;
                step  <= 1'b1;
                if (count_inc == per_sel) begin
                    count <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= count_inc[WIDTH-1:0];
                end
            end
        end
    end

endmodule
